mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_if.sv | 36 +++
 rtl/mc_control.sv | 156 +++++++++++++++
 tb/tb_mc_control.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Bundle of the multicycle controller's datapath-facing signals.
// master = controller side, slave = datapath side.
interface mc_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-style main control FSM (lw, sw, R-type, beq, j).
// Define MC_CONTROL_ADDI_EN to add the addi path (IEX -> IWB).
module mc_control (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
`ifdef MC_CONTROL_ADDI_EN
    JMP    = 4'd9,
    IEX    = 4'd10,
    IWB    = 4'd11
`else
    JMP    = 4'd9
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  assign bus.state = state_q;

  // IRWrite/PCWrite are gated by rst_n so a held reset never commits a fetch.
  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal     = 1'b0;

    case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        if (bus.mem_ready) begin
          bus.IRWrite = rst_n;
          bus.PCWrite = rst_n;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        opcode_d    = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:     state_d = REX;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JMP;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_d = IEX;
`endif
          default: begin
            state_d     = FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      // Routing uses the opcode captured in DECODE, not the live input.
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (opcode_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      REX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_d     = RWB;
      end
      RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_d      = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        state_d         = FETCH;
      end
      JMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        state_d      = FETCH;
      end
`ifdef MC_CONTROL_ADDI_EN
      IEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = IWB;
      end
      IWB: begin
        bus.RegWrite = 1'b1;
        state_d      = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control: each instruction is expanded
// into its expected state walk and per-state control word from the ISA rules.
module tb_mc_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks_total  = 0;
  int   checks_passed = 0;

  mc_control_if bus ();

  mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Observed control word, packed in a fixed field order for comparison.
  logic [16:0] act_vec;
  assign act_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                    bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                    bus.PCSource, bus.illegal};

  // Expected control word for a state, from the per-state strobe table.
  function automatic logic [16:0] exp_vec(input int st, input logic mr, input bit ill);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, asa = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill && st == 1};
  endfunction

  // Advance to the next negedge, drive inputs, and check state and control word.
  task automatic cycle(input int exp_st, input logic mr, input logic [5:0] op,
                       input bit ill, input string name);
    logic [16:0] ev;
    @(negedge clk);
    bus.mem_ready = mr;
    bus.opcode    = op;
    bus.zero      = 1'($urandom);
    #1;
    ev = exp_vec(exp_st, mr, ill);
    checks_total++;
    if (bus.state !== 4'(exp_st))
      $display("[TB] FAIL %s state: got %0d expected %0d", name, bus.state, exp_st);
    else checks_passed++;
    checks_total++;
    if (act_vec !== ev)
      $display("[TB] FAIL %s ctrl (state %0d): got %b expected %b", name, exp_st, act_vec, ev);
    else checks_passed++;
  endtask

  // Expand one instruction into its state walk, inserting wait cycles.
  task automatic run_instr(input logic [5:0] op, input int fetch_stall,
                           input int mem_stall, input string name);
    int path[$];
    bit ill = 0;
    int n;
    logic [5:0] drive_op;
    case (op)
      OP_LW:    path = '{0, 1, 2, 3, 4};
      OP_SW:    path = '{0, 1, 2, 5};
      OP_RTYPE: path = '{0, 1, 6, 7};
      OP_BEQ:   path = '{0, 1, 8};
      OP_J:     path = '{0, 1, 9};
`ifdef MC_CONTROL_ADDI_EN
      OP_ADDI:  path = '{0, 1, 10, 11};
`endif
      default: begin path = '{0, 1}; ill = 1; end
    endcase
    foreach (path[i]) begin
      // After DECODE the opcode input is scrambled: routing must use the latched copy.
      drive_op = (path[i] <= 1) ? op : 6'($urandom);
      if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
        n = (path[i] == 0) ? fetch_stall : mem_stall;
        for (int k = 0; k < n; k++) cycle(path[i], 1'b0, drive_op, ill, name);
        cycle(path[i], 1'b1, drive_op, ill, name);
      end else begin
        cycle(path[i], 1'($urandom), drive_op, ill, name);
      end
    end
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_LW;
    bus.zero      = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    checks_total++;
    if (bus.state !== 4'd0) $display("[TB] FAIL reset_async state: got %0d expected 0", bus.state);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (bus.state !== 4'd0) $display("[TB] FAIL reset_hold state: got %0d expected 0", bus.state);
    else checks_passed++;
    checks_total++;
    if (act_vec !== exp_vec(0, 1'b0, 0))
      $display("[TB] FAIL reset_ctrl: got %b expected %b", act_vec, exp_vec(0, 1'b0, 0));
    else checks_passed++;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();          run_instr(OP_LW, 0, 0, "lw");          endtask
  task automatic test_sw_stall();    run_instr(OP_SW, 0, 3, "sw_stall");    endtask
  task automatic test_fetch_stall(); run_instr(OP_J, 5, 0, "fetch_stall"); endtask

  task automatic test_rtype_beq();
    run_instr(OP_RTYPE, 0, 0, "rtype");
    run_instr(OP_BEQ, 0, 0, "beq");
  endtask

  task automatic test_illegal_addi();
    run_instr(OP_BAD, 0, 0, "illegal");
    run_instr(OP_ADDI, 0, 0, "addi");
  endtask

  task automatic test_lw_stall_mem();
    run_instr(OP_LW, 1, 2, "lw_stall");
  endtask

  task automatic test_async_reset();
    cycle(0, 1'b1, OP_LW, 0, "async_rst");
    cycle(1, 1'b1, OP_LW, 0, "async_rst");
    cycle(2, 1'b1, 6'($urandom), 0, "async_rst");
    cycle(3, 1'b0, 6'($urandom), 0, "async_rst");
    #1;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (bus.state !== 4'd0) $display("[TB] FAIL async_rst_mid state: got %0d expected 0", bus.state);
    else checks_passed++;
    checks_total++;
    if (act_vec !== exp_vec(0, 1'b0, 0))
      $display("[TB] FAIL async_rst_gate: got %b expected %b", act_vec, exp_vec(0, 1'b0, 0));
    else checks_passed++;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks_total++;
    if (bus.state !== 4'd0 || bus.MemRead !== 1'b1)
      $display("[TB] FAIL async_rst_release: got state %0d MemRead %b expected 0/1", bus.state, bus.MemRead);
    else checks_passed++;
    run_instr(OP_J, 0, 0, "after_rst");
  endtask

  // Random back-to-back instruction stream with random wait states.
  task automatic test_back_to_back();
    logic [5:0] op;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_RTYPE;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        6: op = OP_BAD;
        default: op = 6'($urandom);
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype_beq();
    test_illegal_addi();
    test_fetch_stall();
    test_lw_stall_mem();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
